// File: rtl/cmp_trigger_filter_if.sv
// Handshake bundle between the trigger filter and its driver: comparator sample stream in,
// trigger pulse and software-visible status out.
interface cmp_trigger_filter_if #(
  parameter int N_CONSEC = 4,
  parameter int CNT_W    = 8
);
  localparam int RUN_W = $clog2(N_CONSEC + 1);

  logic             i_arm;
  logic             i_clear;
  logic             i_in_valid;
  logic             i_cmp_out;
  logic             o_trig;
  logic             o_armed;
  logic [RUN_W-1:0] o_run_len;
  logic [CNT_W-1:0] o_evt_count;
  logic             o_overflow;

  modport master (
    output i_arm, i_clear, i_in_valid, i_cmp_out,
    input  o_trig, o_armed, o_run_len, o_evt_count, o_overflow
  );

  modport slave (
    input  i_arm, i_clear, i_in_valid, i_cmp_out,
    output o_trig, o_armed, o_run_len, o_evt_count, o_overflow
  );
endinterface

// File: rtl/cmp_trigger_filter.sv
// Fires a one-cycle trigger after N_CONSEC consecutive true comparator samples, then ignores input
// for HOLDOFF cycles; 1-cycle registered latency, no backpressure (every valid sample is consumed).
module cmp_trigger_filter #(
  parameter int N_CONSEC = 4,
  parameter int HOLDOFF  = 3,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  cmp_trigger_filter_if.slave bus
);
  localparam int RUN_W  = $clog2(N_CONSEC + 1);
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [RUN_W-1:0]  LP_RUN_LAST  = RUN_W'(N_CONSEC - 1);
  localparam logic [HOLD_W-1:0] LP_HOLD_LOAD = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              r_state;
  logic [RUN_W-1:0]    r_run_len;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_trig;
  logic [CNT_W-1:0]    r_evt_count;
  logic                r_overflow;

  state_t              w_state_nxt;
  logic [RUN_W-1:0]    w_run_nxt;
  logic [HOLD_W-1:0]   w_hold_nxt;
  logic                w_trig_nxt;
  logic [CNT_W-1:0]    w_evt_nxt;
  logic                w_ovf_nxt;
  logic                w_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_run_len   <= '0;
      r_hold_cnt  <= '0;
      r_trig      <= 1'b0;
      r_evt_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_run_len   <= w_run_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_trig      <= w_trig_nxt;
      r_evt_count <= w_evt_nxt;
      r_overflow  <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run_len;
    w_hold_nxt  = r_hold_cnt;
    w_trig_nxt  = 1'b0;
    w_evt_nxt   = r_evt_count;
    w_ovf_nxt   = r_overflow;
    w_fire      = 1'b0;

    if (bus.i_clear) begin
      w_state_nxt = S_IDLE;
      w_run_nxt   = '0;
      w_hold_nxt  = '0;
      w_evt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else if (!bus.i_arm) begin
      // Disarming keeps the event history for software readback.
      w_state_nxt = S_IDLE;
      w_run_nxt   = '0;
      w_hold_nxt  = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_WAIT;
          w_run_nxt   = '0;
        end
        S_WAIT: begin
          if (bus.i_in_valid) begin
            if (!bus.i_cmp_out) begin
              w_run_nxt = '0;
            end else if (r_run_len == LP_RUN_LAST) begin
              w_fire = 1'b1;
            end else begin
              w_run_nxt = r_run_len + 1'b1;
            end
          end
        end
        S_HOLD: begin
          w_run_nxt = '0;
          if (r_hold_cnt == '0) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_hold_nxt = r_hold_cnt - 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_run_nxt   = '0;
        end
      endcase

      if (w_fire) begin
        w_trig_nxt = 1'b1;
        w_run_nxt  = '0;
        if (&r_evt_count) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_evt_nxt = r_evt_count + 1'b1;
        end
        if (HOLDOFF > 0) begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = LP_HOLD_LOAD;
        end
      end
    end
  end

  assign bus.o_trig      = r_trig;
  assign bus.o_armed     = (r_state != S_IDLE);
  assign bus.o_run_len   = r_run_len;
  assign bus.o_evt_count = r_evt_count;
  assign bus.o_overflow  = r_overflow;
endmodule

// File: tb/tb_cmp_trigger_filter.sv
// Scoreboard bench: a behavioural model predicts each cycle's outputs from the driven inputs,
// and an independent monitor compares them against the DUT one clock later.
module tb_cmp_trigger_filter;
  localparam int N_CONSEC = 4;
  localparam int HOLDOFF  = 3;
  localparam int CNT_W    = 2;
  localparam int EVT_MAX  = (1 << CNT_W) - 1;

  typedef struct {
    int trig;
    int armed;
    int run;
    int evt;
    int ovf;
  } exp_t;

  logic clk;
  logic rst_n;

  cmp_trigger_filter_if #(.N_CONSEC(N_CONSEC), .CNT_W(CNT_W)) bus ();

  cmp_trigger_filter #(
    .N_CONSEC(N_CONSEC),
    .HOLDOFF (HOLDOFF),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  // Reference state: hold-off is tracked as "samples still to ignore".
  int m_armed, m_run, m_hold_left, m_evt, m_ovf, m_trig;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_run = 0; m_hold_left = 0; m_evt = 0; m_ovf = 0; m_trig = 0;
  endtask

  task automatic model_step(input bit a, input bit c, input bit v, input bit d);
    m_trig = 0;
    if (c) begin
      m_armed = 0; m_run = 0; m_hold_left = 0; m_evt = 0; m_ovf = 0;
    end else if (!a) begin
      m_armed = 0; m_run = 0; m_hold_left = 0;
    end else if (!m_armed) begin
      m_armed = 1; m_run = 0;
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      m_run = 0;
    end else if (v) begin
      if (!d) m_run = 0;
      else begin
        m_run++;
        if (m_run == N_CONSEC) begin
          m_run = 0;
          m_trig = 1;
          if (m_evt < EVT_MAX) m_evt++;
          else m_ovf = 1;
          m_hold_left = HOLDOFF;
        end
      end
    end
  endtask

  task automatic drive(input bit a, input bit c, input bit v, input bit d);
    exp_t e;
    bus.i_arm      = a;
    bus.i_clear    = c;
    bus.i_in_valid = v;
    bus.i_cmp_out  = d;
    model_step(a, c, v, d);
    e.trig = m_trig; e.armed = m_armed; e.run = m_run; e.evt = m_evt; e.ovf = m_ovf;
    q.push_back(e);
  endtask

  task automatic step(input bit a, input bit c, input bit v, input bit d);
    @(posedge clk);
    #2;
    drive(a, c, v, d);
  endtask

  task automatic trues(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_trig"},  int'(bus.o_trig), 0);
    chk({tag, "_armed"}, int'(bus.o_armed), 0);
    chk({tag, "_run"},   int'(bus.o_run_len), 0);
    chk({tag, "_evt"},   int'(bus.o_evt_count), 0);
    chk({tag, "_ovf"},   int'(bus.o_overflow), 0);
  endtask

  // Monitor: outputs are presented every cycle; compare one cycle after each pushed sample.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("trig",      int'(bus.o_trig),      e.trig);
        chk("armed",     int'(bus.o_armed),     e.armed);
        chk("run_len",   int'(bus.o_run_len),   e.run);
        chk("evt_count", int'(bus.o_evt_count), e.evt);
        chk("overflow",  int'(bus.o_overflow),  e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.i_arm      = 1'b0;
    bus.i_clear    = 1'b0;
    bus.i_in_valid = 1'b0;
    bus.i_cmp_out  = 1'b0;
    model_reset();
    #3;
    chk_all_zero("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Arming-cycle sample is dropped, then a basic run of 4 and a second run across hold-off.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    trues(11);
    idles(2);

    // 1,1,0,1,1,1,1 with valid gaps between samples.
    begin
      bit pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
        step(1'b1, 1'b0, 1'b1, pat[i]);
        step(1'b1, 1'b0, 1'b0, 1'b1);
      end
    end
    idles(3);

    // Two more fires drive the 2-bit counter into saturation and overflow.
    for (int k = 0; k < 2; k++) begin
      trues(4);
      idles(3);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Clear collides with the firing sample.
    trues(3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Arm dropped in the middle of hold-off, then re-armed.
    trues(4);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    trues(5);
    idles(3);

    // Asynchronous reset mid-run with run_len = 3.
    trues(3);
    @(posedge clk);
    #3;
    chk("pre_reset_run", int'(bus.o_run_len), 3);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    trues(5);
    idles(4);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(99) < 95), ($urandom_range(99) < 2),
           ($urandom_range(99) < 70), ($urandom_range(99) < 75));
    end

    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cmp_trigger_filter.md
# cmp_trigger_filter

Sequential qualifier that sits directly downstream of the SEL-programmable magnitude/equality comparator and consumes its 1-bit predicate result. It accepts a valid-qualified stream of comparator results. It fires a one-cycle trigger after a programmable run of consecutive true results, then ignores input for a hold-off window. It also keeps a saturating event count with a sticky overflow flag for software readback.

## Interface
Parameters:
- N_CONSEC, 4, consecutive true samples required to fire; legal range 1..255
- HOLDOFF, 3, clock cycles after a trigger during which samples are ignored; 0 disables hold-off
- CNT_W, 8, width of the event counter; minimum 1

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  level enable; low forces IDLE
- clear  in  1  synchronous clear; highest priority after reset
- in_valid  in  1  cmp_out is a valid sample this cycle
- cmp_out  in  1  comparator predicate result
- trig  out  1  registered one-cycle trigger pulse
- armed  out  1  high when state is not IDLE
- run_len  out  clog2(N_CONSEC+1)  current consecutive-true count
- evt_count  out  CNT_W  saturating count of triggers
- overflow  out  1  sticky; a trigger occurred while evt_count was at its maximum

## Operation
- Reset value of every register is 0:
  - state = IDLE
  - trig = 0, armed = 0, run_len = 0, evt_count = 0, overflow = 0
  - hold-off counter = 0
- Priority at each edge: clear, then arm = 0, then state behaviour.
- clear = 1 has this effect at the next edge:
  - state = IDLE; run_len, evt_count, overflow, trig and the hold-off counter all become 0.
  - The sample presented in that cycle is dropped.
- clear = 0 and arm = 0: state = IDLE, run_len = 0, trig = 0. evt_count and overflow are retained.
- States:
  - IDLE: samples ignored. arm = 1 moves to WAIT at the next edge. The sample presented in the arming cycle is not counted.
  - WAIT, accepted sample (in_valid = 1):
    - cmp_out = 0: run_len becomes 0.
    - cmp_out = 1 and run_len + 1 < N_CONSEC: run_len increments.
    - cmp_out = 1 and run_len + 1 == N_CONSEC: this is a fire.
  - WAIT, no sample (in_valid = 0): run_len holds. Gaps in valid do not break a run.
  - HOLDOFF: the counter loads HOLDOFF - 1 on entry and decrements every clock, regardless of in_valid. All samples are ignored and run_len stays 0. When the counter reads 0, the next edge returns to WAIT.
- Fire, all at the same edge:
  - trig = 1 for exactly one cycle, and run_len = 0.
  - If evt_count < 2^CNT_W - 1, evt_count increments. Otherwise evt_count holds and overflow is set.
  - If HOLDOFF > 0, go to HOLDOFF. If HOLDOFF == 0, stay in WAIT; the next accepted sample starts a new run.
- Width rules:
  - run_len never exceeds N_CONSEC - 1 when observed.
  - evt_count never wraps.
  - overflow clears only on reset or clear.
- N_CONSEC = 1: every accepted true sample in WAIT fires.
- arm dropping during HOLDOFF: the hold-off is abandoned and the state becomes IDLE. Re-arming starts in WAIT with run_len = 0.

## Timing
- Inputs are sampled at the rising edge of clk. Outputs are registered, with no combinational path from input to output.
- Fire latency: if the N_CONSEC-th true sample is presented in cycle t, trig is high in cycle t+1 only. evt_count and overflow update in that same cycle t+1.
- Hold-off window: samples presented in cycles t+1 through t+HOLDOFF are ignored. The first sample evaluated is the one presented in cycle t+HOLDOFF+1.
- armed rises the cycle after the first edge with arm = 1. It falls the cycle after the first edge with arm = 0 or clear = 1.
- Asynchronous reset: outputs go to 0 immediately. This holds even mid-run or mid-hold-off, including a trig already in flight. Operation resumes on the first edge after rst_n deasserts.
- Simultaneous clear and a firing sample: clear wins. No trig is produced and the count becomes 0.

## Test plan
- Default parameters. Reset, arm = 1, then in_valid = 1 with cmp_out = 1,1,1,1 -> trig high exactly one cycle after the 4th sample, evt_count = 1, run_len back to 0.
- Pattern 1,1,0,1,1,1,1 with in_valid = 1 and valid gaps (0) inserted between samples -> the 0 resets run_len. A single trig follows the final 1. The gaps hold run_len.
- HOLDOFF = 3: trig, then continuous true samples -> samples in the 3 cycles after the trig are ignored. The next trig comes exactly 4 + 3 cycles after the first.
- CNT_W = 2: fire 5 times -> evt_count reads 1,2,3,3,3. overflow rises with the 4th trig and stays high until clear pulses, after which both read 0.
- clear asserted in the same cycle as the firing sample -> no trig, evt_count = 0, state IDLE. arm dropped during hold-off -> state IDLE, armed = 0 next cycle.
- rst_n pulled low asynchronously mid-run with run_len = 3 -> all outputs read 0 before the next clock edge. After release and re-arm, a full run of 4 is required to fire.
